// File: rtl/i4001_rom.sv
// 4001-style mask ROM with a 4-bit I/O port, sitting on the shared 4-bit CPU bus.
// It follows the 8-phase instruction cycle and snoops the bus for SRC, WRR and RDR.
module i4001_rom #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] dbus_in,
  output logic [3:0] dbus_out,
  output logic       dbus_oe,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_t;

  phase_t     phase_r, phase_nxt_s;
  logic       locked_r, selected_r, src_sel_r;
  logic       operand_r, pend_r;
  logic [3:0] addr_lo_r, addr_hi_r, opr_r, opa_r;
  logic [3:0] io_meta_r, io_sync_r;
  logic [7:0] rom_q_r;
  logic [7:0] rom [256];
  logic       rdr_s;

  // Opcodes whose following fetch is an operand byte (JCN, FIM, JUN, JMS, ISZ).
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    case (opr)
      4'h1, 4'h4, 4'h5, 4'h7: is_two_word = 1'b1;
      4'h2:                   is_two_word = ~opa[0];
      default:                is_two_word = 1'b0;
    endcase
  endfunction

  // Next phase: sync marks X3 (or forces a resync), otherwise count round the cycle.
  always_comb begin
    phase_nxt_s = PH_A1;
    if (sync) begin
      phase_nxt_s = PH_A1;
    end else begin
      phase_nxt_s = phase_t'(phase_r + 3'd1);
    end
  end

  // Phase, lock, address/opcode capture, operand tracking and I/O port state.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r    <= PH_A1;
      locked_r   <= 1'b0;
      selected_r <= 1'b0;
      src_sel_r  <= 1'b0;
      operand_r  <= 1'b0;
      pend_r     <= 1'b0;
      addr_lo_r  <= 4'h0;
      addr_hi_r  <= 4'h0;
      opr_r      <= 4'h0;
      opa_r      <= 4'h0;
      io_meta_r  <= 4'h0;
      io_sync_r  <= 4'h0;
      io_out     <= 4'h0;
    end else begin
      phase_r   <= phase_nxt_s;
      io_meta_r <= io_in;
      io_sync_r <= io_meta_r;
      if (sync) locked_r <= 1'b1;
      if (locked_r) begin
        case (phase_r)
          PH_A1: addr_lo_r <= dbus_in;
          PH_A2: addr_hi_r <= dbus_in;
          PH_A3: selected_r <= (dbus_in == CHIP_ID);
          PH_M1: opr_r <= dbus_in;
          PH_M2: begin
            opa_r  <= dbus_in;
            pend_r <= ~operand_r & is_two_word(opr_r, dbus_in);
          end
          PH_X2: begin
            if (cm_rom && !operand_r) begin
              if (opr_r == 4'h2 && opa_r[0]) begin
                src_sel_r <= (dbus_in == CHIP_ID);
              end else if (opr_r == 4'hE && opa_r == 4'h2 && src_sel_r) begin
                io_out <= dbus_in;
              end
            end
          end
          default: ;
        endcase
      end
      // The operand flag hands over at the fetch boundary; an aborted fetch clears it.
      if (sync) begin
        operand_r <= pend_r;
        pend_r    <= 1'b0;
      end
    end
  end

  // Host write port and A3 read; a same-edge write/read at one address returns the old byte.
  always_ff @(posedge clk) begin
    if (prog_we) rom[prog_addr] <= prog_data;
    if (locked_r && phase_r == PH_A3) rom_q_r <= rom[{addr_hi_r, addr_lo_r}];
  end

  assign rdr_s = cm_rom && !operand_r && src_sel_r && opr_r == 4'hE && opa_r == 4'hA;

  // Bus drive: ROM nibbles in M1/M2 when selected, port read-back in X2 of an RDR.
  always_comb begin
    dbus_out = 4'h0;
    dbus_oe  = 1'b0;
    if (locked_r) begin
      case (phase_r)
        PH_M1: begin
          if (selected_r) begin
            dbus_out = rom_q_r[7:4];
            dbus_oe  = 1'b1;
          end else begin
            dbus_oe  = 1'b0;
          end
        end
        PH_M2: begin
          if (selected_r) begin
            dbus_out = rom_q_r[3:0];
            dbus_oe  = 1'b1;
          end else begin
            dbus_oe  = 1'b0;
          end
        end
        PH_X2: begin
          if (rdr_s) begin
            dbus_out = io_sync_r;
            dbus_oe  = 1'b1;
          end else begin
            dbus_oe  = 1'b0;
          end
        end
        default: dbus_oe = 1'b0;
      endcase
    end else begin
      dbus_oe = 1'b0;
    end
  end

endmodule

// File: tb/tb_i4001_rom.sv
// Bench for i4001_rom: directed vector table, hand-written reset/resync sequences
// and random instruction cycles checked against an instruction-level model.
module tb_i4001_rom;

  localparam logic [3:0] CHIP = 4'h3;

  logic       clk, rst, sync, cm_rom, dbus_oe, prog_we;
  logic [3:0] dbus_in, dbus_out, io_in, io_out, cpu_bus;
  logic [7:0] prog_addr, prog_data;

  assign dbus_in = dbus_oe ? dbus_out : cpu_bus;

  i4001_rom #(.CHIP_ID(CHIP)) dut (
    .clk(clk), .rst(rst), .sync(sync), .cm_rom(cm_rom),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
    .io_in(io_in), .io_out(io_out),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a_lo, a_hi, chip, opr, opa;
    logic       cm;
    logic [3:0] x2, io;
    logic       a3_we;
    logic [7:0] wdata;
    logic       m1_oe;
    logic [3:0] m1, m2;
    logic       x2_oe;
    logic [3:0] x2_out, io_exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_rom [256];
  logic       m_src, m_pend;
  logic [3:0] m_io;
  vec_t       tbl [20];
  vec_t       v, e;

  function automatic vec_t mk(input logic [3:0] a_lo, a_hi, chip, opr, opa, input logic cm,
                              input logic [3:0] x2, io, input logic we, input logic [7:0] wdata,
                              input logic m1_oe, input logic [3:0] m1, m2,
                              input logic x2_oe, input logic [3:0] x2_out, io_exp);
    mk = {a_lo, a_hi, chip, opr, opa, cm, x2, io, we, wdata, m1_oe, m1, m2, x2_oe, x2_out, io_exp};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: what this chip must do for one whole fetch.
  task automatic predict(input vec_t vin, output vec_t eo);
    logic       sel, operand;
    logic [7:0] b;
    logic [3:0] opr, opa;
    eo      = vin;
    sel     = (vin.chip == CHIP);
    b       = m_rom[{vin.a_hi, vin.a_lo}];
    if (vin.a3_we) m_rom[{vin.a_hi, vin.a_lo}] = vin.wdata;
    opr     = sel ? b[7:4] : vin.opr;
    opa     = sel ? b[3:0] : vin.opa;
    operand = m_pend;
    eo.m1_oe  = sel;
    eo.m1     = sel ? b[7:4] : 4'h0;
    eo.m2     = sel ? b[3:0] : 4'h0;
    eo.x2_oe  = !operand && vin.cm && m_src && opr == 4'hE && opa == 4'hA;
    eo.x2_out = eo.x2_oe ? vin.io : 4'h0;
    if (!operand && vin.cm && opr == 4'h2 && opa[0]) m_src = (vin.x2 == CHIP);
    else if (!operand && vin.cm && m_src && opr == 4'hE && opa == 4'h2) m_io = vin.x2;
    eo.io_exp = m_io;
    m_pend = !operand && ((opr inside {4'h1, 4'h4, 4'h5, 4'h7}) || (opr == 4'h2 && !opa[0]));
  endtask

  // Drive one full A1..X3 cycle (caller leaves sync=1 in the cycle before) and check it.
  task automatic apply(input vec_t vv, input string tag);
    for (int p = 0; p < 8; p++) begin
      step();
      sync    = (p == 7);
      cm_rom  = (p == 6) ? vv.cm : 1'b0;
      prog_we = 1'b0;
      if (p == 0) io_in = vv.io;
      case (p)
        0: cpu_bus = vv.a_lo;
        1: cpu_bus = vv.a_hi;
        2: begin
          cpu_bus = vv.chip;
          if (vv.a3_we) begin
            prog_we   = 1'b1;
            prog_addr = {vv.a_hi, vv.a_lo};
            prog_data = vv.wdata;
          end
        end
        3: cpu_bus = vv.opr;
        4: cpu_bus = vv.opa;
        6: cpu_bus = vv.x2;
        default: cpu_bus = 4'($urandom_range(0, 15));
      endcase
      @(negedge clk);
      case (p)
        3: begin
          chk($sformatf("%s.m1_oe", tag), {7'h0, dbus_oe}, {7'h0, vv.m1_oe});
          chk($sformatf("%s.m1", tag), {4'h0, dbus_out}, {4'h0, vv.m1});
        end
        4: begin
          chk($sformatf("%s.m2_oe", tag), {7'h0, dbus_oe}, {7'h0, vv.m1_oe});
          chk($sformatf("%s.m2", tag), {4'h0, dbus_out}, {4'h0, vv.m2});
        end
        6: begin
          chk($sformatf("%s.x2_oe", tag), {7'h0, dbus_oe}, {7'h0, vv.x2_oe});
          chk($sformatf("%s.x2", tag), {4'h0, dbus_out}, {4'h0, vv.x2_out});
        end
        7: begin
          chk($sformatf("%s.x3_oe", tag), {7'h0, dbus_oe}, 8'h00);
          chk($sformatf("%s.io_out", tag), {4'h0, io_out}, {4'h0, vv.io_exp});
        end
        default: chk($sformatf("%s.ph%0d_oe", tag, p), {7'h0, dbus_oe}, 8'h00);
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; cpu_bus = 4'h0; io_in = 4'h0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
    m_src = 1'b0; m_pend = 1'b0; m_io = 4'h0;

    //            lo    hi    chip  opr   opa   cm    x2    io    we    wdata  m1oe  m1    m2    x2oe  x2o   io
    tbl[0]  = mk(4'hA, 4'h5, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 4'hD, 4'h7, 1'b0, 4'h0, 4'h0);
    tbl[1]  = mk(4'hA, 4'h5, 4'h2, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tbl[2]  = mk(4'h0, 4'h1, 4'h0, 4'h2, 4'h1, 1'b1, 4'h3, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tbl[3]  = mk(4'h1, 4'h1, 4'h0, 4'hE, 4'h2, 1'b1, 4'h9, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9);
    tbl[4]  = mk(4'h2, 4'h1, 4'h0, 4'hE, 4'hA, 1'b1, 4'h0, 4'h6, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 4'h6, 4'h9);
    tbl[5]  = mk(4'h3, 4'h1, 4'h0, 4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9);
    tbl[6]  = mk(4'h4, 4'h1, 4'h0, 4'hE, 4'h2, 1'b1, 4'h5, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9);
    tbl[7]  = mk(4'h5, 4'h1, 4'h0, 4'hE, 4'h2, 1'b1, 4'hC, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hC);
    tbl[8]  = mk(4'h6, 4'h1, 4'h0, 4'h2, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hC);
    tbl[9]  = mk(4'h7, 4'h1, 4'h0, 4'h2, 4'h1, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hC);
    tbl[10] = mk(4'h8, 4'h1, 4'h0, 4'hE, 4'h2, 1'b1, 4'hA, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hA);
    tbl[11] = mk(4'h9, 4'h1, 4'h0, 4'h2, 4'h1, 1'b1, 4'h5, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hA);
    tbl[12] = mk(4'hA, 4'h1, 4'h0, 4'hE, 4'h2, 1'b1, 4'hF, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hA);
    tbl[13] = mk(4'hB, 4'h1, 4'h0, 4'h2, 4'h1, 1'b1, 4'h3, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hA);
    tbl[14] = mk(4'hC, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hA);
    tbl[15] = mk(4'hD, 4'h1, 4'h0, 4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'hA);
    tbl[16] = mk(4'hE, 4'h1, 4'h0, 4'hE, 4'h2, 1'b1, 4'h7, 4'h0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h7);
    tbl[17] = mk(4'hF, 4'h1, 4'h0, 4'hE, 4'hA, 1'b0, 4'h0, 4'h5, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h7);
    tbl[18] = mk(4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 8'h99, 1'b1, 4'h6, 4'h6, 1'b0, 4'h0, 4'h7);
    tbl[19] = mk(4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 4'h9, 4'h9, 1'b0, 4'h0, 4'h7);

    repeat (3) step();
    @(negedge clk);
    chk("rst.oe", {7'h0, dbus_oe}, 8'h00);
    chk("rst.out", {4'h0, dbus_out}, 8'h00);
    chk("rst.io_out", {4'h0, io_out}, 8'h00);
    step();
    rst = 1'b0;

    // Load the ROM through the host port while the chip is still unlocked.
    for (int i = 0; i < 256; i++) begin
      prog_we   = 1'b1;
      prog_addr = 8'(i);
      prog_data = (i == 8'h5A) ? 8'hD7 : (i == 8'h33) ? 8'h66 : 8'($urandom_range(0, 255));
      m_rom[i]  = prog_data;
      step();
    end
    prog_we = 1'b0;

    // Unlocked: an address pattern that would select this chip must not drive the bus.
    for (int p = 0; p < 8; p++) begin
      step();
      cpu_bus = (p == 0) ? 4'hA : (p == 1) ? 4'h5 : 4'h3;
      @(negedge clk);
      chk($sformatf("unlocked.ph%0d_oe", p), {7'h0, dbus_oe}, 8'h00);
    end

    step();
    sync = 1'b1;
    for (int i = 0; i < 20; i++) begin
      predict(tbl[i], e);
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Resync inside A3 aborts the fetch; the would-be M1 cycle must stay quiet.
    step(); sync = 1'b0; cpu_bus = 4'hA;
    step(); cpu_bus = 4'h5;
    step(); cpu_bus = 4'h3; sync = 1'b1;
    @(negedge clk);
    chk("resync.a3_oe", {7'h0, dbus_oe}, 8'h00);
    step(); cpu_bus = 4'hD;
    @(negedge clk);
    chk("resync.next_oe", {7'h0, dbus_oe}, 8'h00);
    predict(tbl[0], e);
    apply(e, "after_resync");

    // Reset during M1 of a selected fetch, then relock and read the same byte.
    step(); sync = 1'b0; cpu_bus = 4'hA;
    step(); cpu_bus = 4'h5;
    step(); cpu_bus = 4'h3;
    step(); cpu_bus = 4'h0; rst = 1'b1;
    @(negedge clk);
    chk("rstm1.oe_before", {7'h0, dbus_oe}, 8'h01);
    chk("rstm1.out_before", {4'h0, dbus_out}, 8'h0D);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rstm1.oe_after", {7'h0, dbus_oe}, 8'h00);
    chk("rstm1.out_after", {4'h0, dbus_out}, 8'h00);
    chk("rstm1.io_out", {4'h0, io_out}, 8'h00);
    m_src = 1'b0; m_pend = 1'b0; m_io = 4'h0;
    step(); sync = 1'b1;
    predict(tbl[0], e);
    apply(e, "relock");

    // Random instruction stream against the model.
    for (int n = 0; n < 80; n++) begin
      v       = '0;
      v.a_lo  = 4'($urandom_range(0, 15));
      v.a_hi  = 4'($urandom_range(0, 15));
      v.chip  = ($urandom_range(0, 2) == 0) ? CHIP : 4'($urandom_range(0, 15));
      v.opr   = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h2 : 4'hE)
                                            : 4'($urandom_range(0, 15));
      v.opa   = ($urandom_range(0, 1) == 0) ? (($urandom_range(0, 1) == 0) ? 4'h2 : 4'hA)
                                            : 4'($urandom_range(0, 15));
      v.cm    = ($urandom_range(0, 3) != 0);
      v.x2    = ($urandom_range(0, 1) == 0) ? CHIP : 4'($urandom_range(0, 15));
      v.io    = 4'($urandom_range(0, 15));
      v.a3_we = ($urandom_range(0, 9) == 0);
      v.wdata = 8'($urandom_range(0, 255));
      predict(v, e);
      apply(e, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i4001_rom.md
I4001_ROM -- requirements
Module: i4001_rom

Interface
REQ-001 SHALL have parameter CHIP_ID, default 4'h0, 4-bit chip number matched against A3 and SRC.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port sync, input, 1: CPU marks the X3 phase; the next cycle is A1.
REQ-005 SHALL have port cm_rom, input, 1: CPU ROM command line.
REQ-006 SHALL have port dbus_in, input, 4: resolved shared data bus.
REQ-007 SHALL have port dbus_out, output, 4: nibble this chip drives.
REQ-008 SHALL have port dbus_oe, output, 1: high when dbus_out is driven.
REQ-009 SHALL have port io_in, input, 4: asynchronous external I/O inputs.
REQ-010 SHALL have port io_out, output, 4: registered I/O output latch.
REQ-011 SHALL have port prog_we, input, 1: host ROM write strobe.
REQ-012 SHALL have port prog_addr, input, 8: host write address.
REQ-013 SHALL have port prog_data, input, 8: host write byte.

Function
REQ-014 SHALL keep a 3-bit phase counter: A1=0, A2, A3, M1, M2, X1, X2, X3=7.
REQ-015 Phase counter SHALL load A1 in the cycle after sync=1, else increment modulo 8.
REQ-016 SHALL hold a "locked" flag, set on first sync=1; while clear, dbus_oe=0 and no latching.
REQ-017 At A1 SHALL latch dbus_in as address bits [3:0]; at A2, bits [7:4].
REQ-018 At A3 SHALL set "selected" = (dbus_in==CHIP_ID) and register rom[addr] into rom_q.
REQ-019 In M1 with selected=1: dbus_out=rom_q[7:4], dbus_oe=1.
REQ-020 In M2 with selected=1: dbus_out=rom_q[3:0], dbus_oe=1.
REQ-021 SHALL snoop dbus_in at M1 (OPR) and M2 (OPA) every cycle, selected or not.
REQ-022 Second-word tracking: after OPR in {1 (JCN), 4 (JUN), 5 (JMS), 7 (ISZ)}, or OPR=2 with OPA[0]=0 (FIM), the next fetch SHALL be flagged operand and not decoded.
REQ-023 An operand-flagged fetch SHALL never itself set the flag (no chaining).
REQ-024 SRC (OPR=2, OPA[0]=1, not operand): at X2 with cm_rom=1, src_sel <= (dbus_in==CHIP_ID).
REQ-025 src_sel SHALL persist until the next SRC or reset.
REQ-026 WRR (OPR=E, OPA=2), src_sel=1, cm_rom=1 at X2: io_out <= dbus_in.
REQ-027 RDR (OPR=E, OPA=A), src_sel=1, cm_rom=1 at X2: dbus_out=io_sync, dbus_oe=1 for that X2 only.
REQ-028 io_in SHALL pass a 2-flop synchronizer (io_sync) before use.
REQ-029 dbus_oe SHALL be 0 in all phases/conditions not listed in REQ-019/020/027.
REQ-030 ROM SHALL be 256x8; prog_we=1 writes prog_data at prog_addr in the same edge.
REQ-031 A prog write and A3 read at the same address in the same cycle SHALL return the old byte.
REQ-032 sync=1 in a phase other than X3 SHALL resync the counter to A1 next cycle; an aborted fetch drives nothing.

Reset
REQ-033 On rst: phase=A1, locked=0, selected=0, src_sel=0, operand flag=0, io_out=0, dbus_oe=0, dbus_out=0, synchronizer=0.
REQ-034 ROM contents SHALL NOT be cleared by rst.
REQ-035 Reset asserted mid-cycle SHALL drop dbus_oe in the next cycle; chip relocks on the next sync.

Verification
REQ-036 CHIP_ID=3, rom[0x5A]=0xD7; bus A1=A, A2=5, A3=3 -> M1 dbus_out=D, M2 dbus_out=7, dbus_oe=1 in M1/M2 only.
REQ-037 Same address, A3=2 -> dbus_oe=0 for the entire instruction cycle.
REQ-038 SRC (OPR=2, OPA=1) with X2 bus=3, cm_rom=1; then WRR with X2 bus=9 -> io_out=9 the following cycle.
REQ-039 io_in=6 held >=3 clocks, src_sel=1, RDR -> dbus_out=6, dbus_oe=1 in X2 only.
REQ-040 JUN (OPR=4) whose operand byte is 0xE2 -> operand not decoded as WRR; io_out unchanged.
REQ-041 rst asserted during M1 of a selected fetch -> dbus_oe=0 and io_out=0 next cycle; ROM byte still readable after relock.
